// File: rtl/fm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fm_pkg
// Description : Shared definitions for the programmable FM modulator:
//               operating-mode encodings and the reset-default phase
//               increment calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package fm_pkg;

  // Operating modes. Both 2'd2 and 2'd3 mute the output.
  typedef enum logic [1:0] {
    MODE_FM       = 2'd0,
    MODE_CW       = 2'd1,
    MODE_MUTE     = 2'd2,
    MODE_MUTE_ALT = 2'd3
  } fm_mode_e;

  // Phase increment for frequency f at clock f_s with an n-bit accumulator.
  // The integer division order is fixed so the defaults come out as
  // 2**n / (f_s / f), e.g. 52428 for 10 MHz at 50 MHz with n = 18.
  function automatic longint inc_from_freq(input longint f_s,
                                           input longint f,
                                           input int     n);
    return (longint'(1) << n) / (f_s / f);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fm_sine_approx.sv
`default_nettype none
// ============================================================================
// Module      : fm_sine_approx
// Description : Combinational coarse sine approximation. Folds the phase
//               into a quarter wave, builds a piecewise-linear magnitude
//               and restores the sign from the quadrant.
// Ports       : phase [R+1:0] in  - top phase bits (quadrant + R fraction)
//               sine  [D-1:0] out - signed sample, range +/-(2**(D-1)-1)
// Revision    : 1.0 - initial release
// ============================================================================
module fm_sine_approx #(
  parameter int R = 12,
  parameter int D = 5
) (
  input  logic [R+1:0]        phase,
  output logic signed [D-1:0] sine
);

  localparam logic [D-2:0] QTR  = (D-1)'(2 ** (D-1) / 4);
  localparam logic [D-2:0] PEAK = '1;

  logic [1:0]   q;
  logic [R-1:0] pr;
  logic [R-1:0] pa;
  logic [1:0]   seg;
  logic [D-2:0] t;
  logic [D-2:0] mag;

  assign q  = phase[R+1:R];
  assign pr = phase[R-1:0];

  // Odd quadrants run backwards through the quarter wave; 2**R-1-pr is ~pr.
  assign pa  = q[0] ? ~pr : pr;
  assign seg = pa[R-1:R-2];
  assign t   = pa[R-1 -: D-1];

  // Steep start, shallower middle, flat top near the peak.
  always_comb begin
    mag = PEAK;
    case (seg)
      2'd0:      mag = {t[D-3:0], 1'b0};
      2'd1,
      2'd2:      mag = QTR + t;
      default:   mag = PEAK;
    endcase
  end

  // Second half of the cycle is the negative lobe.
  assign sine = q[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

  // Fraction bits below the magnitude resolution do not affect the output.
  generate
    if (R > D - 1) begin : g_low_bits
      logic unused_pa_low;
      assign unused_pa_low = ^pa[R-D:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fm_modulator_prog.sv
`default_nettype none
// ============================================================================
// Module      : fm_modulator_prog
// Description : Direct-digital FM modulator with runtime-programmable carrier
//               and deviation increments. New increments are written to
//               shadow registers and copied into the active set only when
//               the phase accumulator wraps, so the carrier never glitches.
// Ports       : clk          in   system clock
//               rst          in   asynchronous active-high reset
//               enable       in   0 clears and holds the accumulator
//               mode [1:0]   in   0 FM, 1 CW, 2/3 mute
//               audio [A-1:0] in  signed audio sample
//               audio_valid  in   capture audio into the hold register
//               cfg_we       in   load cfg_fc_inc / cfg_df_inc into shadows
//               cfg_fc_inc   in   carrier phase increment (unsigned)
//               cfg_df_inc   in   full-scale deviation increment (unsigned)
//               cfg_pending  out  shadow written but not yet applied
//               phase_wrap   out  accumulator carried out on last update
//               rf [D-1:0]   out  unsigned DAC code, midscale 2**(D-1)
// Revision    : 1.0 - initial release
// ============================================================================
module fm_modulator_prog
  import fm_pkg::*;
#(
  parameter int     A   = 8,
  parameter int     N   = 18,
  parameter int     M   = 14,
  parameter int     D   = 5,
  parameter longint F_S = 50000000,
  parameter longint F_C = 10000000,
  parameter longint DF  = 75000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic signed [A-1:0] audio,
  input  logic                audio_valid,
  input  logic                cfg_we,
  input  logic [N-1:0]        cfg_fc_inc,
  input  logic [N-1:0]        cfg_df_inc,
  output logic                cfg_pending,
  output logic                phase_wrap,
  output logic [D-1:0]        rf
);

  localparam int           R      = M - 2;
  localparam logic [N-1:0] FC_DEF = N'(inc_from_freq(F_S, F_C, N));
  localparam logic [N-1:0] DF_DEF = N'(inc_from_freq(F_S, DF, N));
  localparam logic [D-1:0] MID    = D'(2 ** (D-1));

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [N-1:0]        phase_acc;
  logic signed [A-1:0] audio_hold;
  logic [N-1:0]        fc_act;
  logic [N-1:0]        df_act;
  logic [N-1:0]        fc_shd;
  logic [N-1:0]        df_shd;
  logic signed [D-1:0] fm_out;

  // --------------------------------------------------------------------------
  // Modulation increment: (audio_hold * df_act) >>> (A-1), truncated to N.
  // Operands are widened to the full product width so the low A+N bits of
  // the signed product are exact; the shift is a plain bit selection.
  // --------------------------------------------------------------------------
  logic signed [A+N-1:0] audio_ext;
  logic signed [A+N-1:0] df_ext;
  logic signed [A+N-1:0] prod;
  logic [N-1:0]          mod_full;
  logic [N-1:0]          mod_inc;
  logic                  unused_prod;

  assign audio_ext   = {{N{audio_hold[A-1]}}, audio_hold};
  assign df_ext      = {{A{1'b0}}, df_act};
  assign prod        = audio_ext * df_ext;
  assign mod_full    = prod[A-1 +: N];
  assign mod_inc     = (mode == MODE_CW) ? '0 : mod_full;
  assign unused_prod = ^{prod[A+N-1], prod[A-2:0]};

  // --------------------------------------------------------------------------
  // Accumulator sum. All three terms are added as unsigned N-bit values (a
  // negative mod_inc is its two's complement pattern), so the sum can carry
  // by up to two; any carry counts as a wrap.
  // --------------------------------------------------------------------------
  logic [N+1:0] acc_sum;
  logic         acc_carry;

  assign acc_sum   = {2'b00, phase_acc} + {2'b00, fc_act} + {2'b00, mod_inc};
  assign acc_carry = |acc_sum[N+1:N];

  // Shadows transfer at a wrap, or on any clock while the accumulator is
  // held, since there is no running carrier to protect then.
  logic apply;
  assign apply = cfg_pending & (~enable | acc_carry);

  // --------------------------------------------------------------------------
  // Sine lookup and output gating
  // --------------------------------------------------------------------------
  logic signed [D-1:0] sine;
  logic                out_on;

  fm_sine_approx #(
    .R (R),
    .D (D)
  ) u_sine (
    .phase (phase_acc[N-1 -: M]),
    .sine  (sine)
  );

  assign out_on = enable & ((mode == MODE_FM) | (mode == MODE_CW));

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio_hold <= '0;
    end else if (audio_valid) begin
      audio_hold <= audio;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_acc  <= '0;
      phase_wrap <= 1'b0;
    end else if (enable) begin
      phase_acc  <= acc_sum[N-1:0];
      phase_wrap <= acc_carry;
    end else begin
      phase_acc  <= '0;
      phase_wrap <= 1'b0;
    end
  end

  // A write coinciding with an apply lands in the shadow and stays pending;
  // the active set takes the previously pending values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_act      <= FC_DEF;
      df_act      <= DF_DEF;
      fc_shd      <= FC_DEF;
      df_shd      <= DF_DEF;
      cfg_pending <= 1'b0;
    end else begin
      if (apply) begin
        fc_act <= fc_shd;
        df_act <= df_shd;
      end
      if (cfg_we) begin
        fc_shd <= cfg_fc_inc;
        df_shd <= cfg_df_inc;
      end
      cfg_pending <= cfg_we | (cfg_pending & ~apply);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fm_out <= '0;
    end else begin
      fm_out <= out_on ? sine : '0;
    end
  end

  // Offset-binary conversion for the DAC.
  assign rf = MID + $unsigned(fm_out);

endmodule
`default_nettype wire

// File: tb/tb_fm_modulator_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_fm_modulator_prog
// Description : Self-checking bench for fm_modulator_prog. An arithmetic
//               reference model is compared against the outputs every cycle,
//               and directed literal checks pin the model's key values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_modulator_prog;

  localparam int     N  = 18;
  localparam int     R  = 12;
  localparam int     D  = 5;
  localparam longint NN = longint'(1) << N;
  localparam longint QW = NN / 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [1:0]        mode;
  logic signed [7:0] audio;
  logic              audio_valid;
  logic              cfg_we;
  logic [N-1:0]      cfg_fc_inc;
  logic [N-1:0]      cfg_df_inc;
  logic              cfg_pending;
  logic              phase_wrap;
  logic [D-1:0]      rf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fm_modulator_prog dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .audio       (audio),
    .audio_valid (audio_valid),
    .cfg_we      (cfg_we),
    .cfg_fc_inc  (cfg_fc_inc),
    .cfg_df_inc  (cfg_df_inc),
    .cfg_pending (cfg_pending),
    .phase_wrap  (phase_wrap),
    .rf          (rf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  longint m_phase, m_fc, m_df, m_fcs, m_dfs, m_hold, m_fm;
  bit     m_pend, m_wrap;

  function automatic longint model_sine(input longint ph);
    longint q, pr, pa, seg, t, mag;
    q   = ph / QW;
    pr  = (ph % QW) / (QW / (longint'(1) << R));
    pa  = (q % 2 == 1) ? ((longint'(1) << R) - 1 - pr) : pr;
    seg = pa / (longint'(1) << (R - 2));
    t   = pa / (longint'(1) << (R - D + 1));
    if (seg == 0)      mag = 2 * t;
    else if (seg == 3) mag = (1 << (D - 1)) - 1;
    else               mag = (1 << (D - 1)) / 4 + t;
    return (q >= 2) ? -mag : mag;
  endfunction

  always @(posedge clk or posedge rst) begin
    longint modv, sum, nfm;
    bit     carry;
    if (rst) begin
      m_phase = 0; m_hold = 0; m_fm = 0;
      m_fc = 52428; m_fcs = 52428; m_df = 393; m_dfs = 393;
      m_pend = 0; m_wrap = 0;
    end else begin
      nfm  = (enable && mode < 2) ? model_sine(m_phase) : 0;
      modv = (mode == 1) ? 0 : ((m_hold * m_df) >>> 7);
      modv = ((modv % NN) + NN) % NN;
      carry = 0;
      if (enable) begin
        sum     = m_phase + m_fc + modv;
        carry   = (sum >= NN);
        m_phase = sum % NN;
      end else begin
        m_phase = 0;
      end
      m_wrap = carry;
      if (m_pend && (!enable || carry)) begin
        m_fc = m_fcs; m_df = m_dfs; m_pend = 0;
      end
      if (cfg_we) begin
        m_fcs = longint'(cfg_fc_inc); m_dfs = longint'(cfg_df_inc); m_pend = 1;
      end
      if (audio_valid) m_hold = longint'(audio);
      m_fm = nfm;
    end
  end

  // Per-cycle comparison, on the falling edge.
  always @(negedge clk) begin
    check("rf", rf, (16 + m_fm) & 31);
    check("phase_wrap", phase_wrap, m_wrap);
    check("cfg_pending", cfg_pending, m_pend);
    check("phase_acc", dut.phase_acc, m_phase);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_wrap(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (phase_wrap === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  int exp_rf [8] = '{16, 31, 16, 1, 16, 31, 16, 1};
  int exp_wr [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd0; audio = '0; audio_valid = 1'b0;
    cfg_we = 1'b0; cfg_fc_inc = '0; cfg_df_inc = '0;
    step(3);
    check("reset_rf", rf, 16);
    check("reset_pending", cfg_pending, 0);
    check("reset_wrap", phase_wrap, 0);

    // Default carrier stepping
    rst = 1'b0; enable = 1'b1;
    step(1);
    check("phase_step1", dut.phase_acc, 52428);
    step(1);
    check("phase_step2", dut.phase_acc, 104856);

    // Program CW quarter-rate carrier, held until the next wrap
    mode = 2'd1; cfg_we = 1'b1; cfg_fc_inc = 18'd65536; cfg_df_inc = 18'd0;
    step(1);
    cfg_we = 1'b0;
    check("cw_pending_set", cfg_pending, 1);
    wait_wrap("cw_wrap_seen");
    check("cw_pending_clr", cfg_pending, 0);
    check("cw_fc_active", dut.fc_act, 65536);
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("cw_rf_seq", rf, exp_rf[i]);
      check("cw_wrap_seq", phase_wrap, exp_wr[i]);
    end

    // Deviation 256, applied while disabled
    mode = 2'd0; cfg_we = 1'b1; cfg_fc_inc = 18'd65536; cfg_df_inc = 18'd256;
    step(1);
    cfg_we = 1'b0; enable = 1'b0;
    step(1);
    check("df_apply_disabled", cfg_pending, 0);
    enable = 1'b1;
    audio = 8'sd127; audio_valid = 1'b1;
    step(1);
    check("mod_inc_p127", dut.mod_inc, 254);
    audio = -8'sd128;
    step(1);
    check("mod_inc_m128", dut.mod_inc, 18'h3FF00);
    audio = -8'sd1;
    step(1);
    check("mod_inc_m1", dut.mod_inc, 18'h3FFFE);
    audio_valid = 1'b0;
    step(2);
    audio = 8'sd0; audio_valid = 1'b1;
    step(1);
    audio_valid = 1'b0;

    // Mid-period reprogramming
    step(1);
    cfg_we = 1'b1; cfg_fc_inc = 18'd32768; cfg_df_inc = 18'd256;
    step(1);
    cfg_we = 1'b0;
    check("mid_pending_set", cfg_pending, 1);
    wait_wrap("mid_wrap_seen");
    check("mid_pending_clr", cfg_pending, 0);
    step(4);

    // Mute keeps phase running, output at midscale
    mode = 2'd2;
    step(1);
    for (int i = 0; i < 6; i++) begin
      check("mute_rf", rf, 16);
      step(1);
    end
    mode = 2'd0;
    step(8);

    // Asynchronous reset with a pending write
    cfg_we = 1'b1; cfg_fc_inc = 18'd1000; cfg_df_inc = 18'd5;
    @(posedge clk);
    #2;
    check("pre_rst_pending", cfg_pending, 1);
    rst = 1'b1;
    #1;
    cfg_we = 1'b0;
    check("arst_rf", rf, 16);
    check("arst_phase", dut.phase_acc, 0);
    check("arst_pending", cfg_pending, 0);
    check("arst_fc_act", dut.fc_act, 52428);
    step(2);
    rst = 1'b0;
    step(1);
    check("post_rst_step", dut.phase_acc, 52428);
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
